keypad_bcd_entry: RTL
=====================

// Module: keypad_bcd_entry
// PURPOSE
//  Sequencer for the decimal key-to-BCD path: synchronises and debounces 10 raw key lines,
//  accepts exactly one key per press/release cycle, encodes it to BCD and shifts it into
//  a NUM_DIGITS BCD entry register that feeds the display/arithmetic stages.
//  Rejects multi-key presses, blocks entry when full and supports synchronous clear.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive identical synced samples needed to accept a press or release (>=2)
//  NUM_DIGITS       4  BCD digits held in the entry register (1..8)
// PORTS
//  clk          in   1              single system clock, rising edge
//  rst_n        in   1              asynchronous active-low reset
//  keys         in   10             raw key lines, keys[k]=1 means decimal key k pressed (async)
//  clear        in   1              synchronous clear of entry register and count
//  digits_out   out  4*NUM_DIGITS   BCD entry, [3:0] = newest digit
//  count        out  4              number of digits entered, 0..NUM_DIGITS
//  full         out  1              count == NUM_DIGITS
//  digit_valid  out  1              1-cycle pulse: digit accepted this cycle
//  digit_bcd    out  4              BCD of last accepted digit (held until next accept)
//  error        out  1              1-cycle pulse: multi-key press or press while full
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; digits_out=0; count=0; full=0; digit_valid=0;
//   digit_bcd=0; error=0; synchroniser flops=0; debounce counter=0.
//  keys pass a 2-flop synchroniser -> ks. FSM operates on ks only.
//  States:
//   IDLE     : ks==0 -> stay. ks!=0 -> latch pat=ks, cnt=1, go PRESS_DB.
//   PRESS_DB : ks!=pat -> IDLE (bounce, no output). ks==pat: cnt++; when cnt reaches
//              DEBOUNCE_CYCLES evaluate pat in that cycle and go WAIT_REL:
//                pat one-hot and !full -> shift: digits_out<=(digits_out<<4)|bcd(pat),
//                  count++, digit_bcd<=bcd(pat), digit_valid=1 next cycle.
//                pat not one-hot -> error=1, no shift.
//                pat one-hot and full -> error=1, no shift, digits unchanged.
//   WAIT_REL : ks!=0 -> cnt=0 (stay). ks==0 -> cnt++; cnt==DEBOUNCE_CYCLES -> IDLE.
//              Any key change while held never produces a second digit.
//  Latency: keys held constant one-hot from cycle t -> digit_valid high in cycle
//   t+2+DEBOUNCE_CYCLES (2 sync + debounce), exactly one cycle wide.
//  Encoding: bit k -> 4'dk (key0 -> 0000 ... key9 -> 1001). Only codes 0..9 ever stored.
//  Shift: oldest digit leaves at top only if NUM_DIGITS exceeded -- never happens, since
//   entry is blocked at full. count saturates at NUM_DIGITS; full is combinational from count.
//  clear=1: digits_out=0, count=0, state->WAIT_REL with cnt=0 (a held key must be
//   released before next entry). clear beats a simultaneous accept: no digit_valid, no shift.
//  digit_valid and error are never high in the same cycle.
//  rst_n asserted mid-debounce: everything returns to reset values immediately;
//   no pulse emitted after deassert until a fresh press completes debounce.
// TESTING
//  1 reset; keys=10'b0000001000 held 20 cycles -> digit_valid 1 pulse at t+6, digit_bcd=3,
//    digits_out=16'h0003, count=1.
//  2 press 1,2,3,4 (release between) -> digits_out=16'h1234, full=1; press 5 -> error pulse,
//    digits_out stays 16'h1234, count=4.
//  3 keys toggling 0<->0x004 every 2 cycles for 20 cycles then 0 -> no digit_valid, no error.
//  4 keys=10'b0000100100 held -> error pulse once, count unchanged; release, press key9
//    -> digit_bcd=9 accepted.
//  5 hold key7 for 100 cycles -> exactly one digit_valid; assert clear while still held ->
//    digits_out=0, count=0, no new digit until release+repress.
//  6 rst_n low during PRESS_DB of key2 -> outputs 0 immediately; after deassert with keys=0
//    no pulse for 50 cycles.

Source files
------------

// File: rtl/keypad_bcd_entry_if.sv
// Bundle of key inputs, clear and BCD entry outputs for the keypad entry block.
interface keypad_bcd_entry_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [9:0]              keys;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [3:0]              count;
  logic                    full;
  logic                    digit_valid;
  logic [3:0]              digit_bcd;
  logic                    error;

  // Driver side (stimulus / keypad front end)
  modport master (
    output keys,
    output clear,
    input  digits_out,
    input  count,
    input  full,
    input  digit_valid,
    input  digit_bcd,
    input  error
  );

  // Entry block side
  modport slave (
    input  keys,
    input  clear,
    output digits_out,
    output count,
    output full,
    output digit_valid,
    output digit_bcd,
    output error
  );
endinterface

// File: rtl/keypad_bcd_entry.sv
// Keypad to BCD entry sequencer: synchronises and debounces ten raw key lines, accepts a
// single key per press/release cycle and shifts its BCD code into the entry register.
module keypad_bcd_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_bcd_entry_if.slave  bus
);

  localparam int unsigned DigW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter is compared before its increment, so the final sample is seen at DEBOUNCE-1.
  localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      CountMax = 4'(NUM_DIGITS);

  typedef enum logic [1:0] {
    StIdle,
    StPressDb,
    StWaitRel
  } state_e;

  state_e          state;
  logic [9:0]      sync1;
  logic [9:0]      ks;
  logic [9:0]      pat;
  logic [CntW-1:0] cnt;
  logic [DigW-1:0] digits;
  logic [3:0]      count;
  logic            digit_valid;
  logic [3:0]      digit_bcd;
  logic            error;
  logic            full;
  logic            pat_onehot;
  logic [3:0]      pat_bcd;

  assign full       = (count == CountMax);
  assign pat_onehot = $onehot(pat);

  // Encode the latched pattern to BCD; only meaningful when pat is one-hot.
  always_comb begin
    pat_bcd = '0;
    for (int k = 0; k < 10; k++) begin
      if (pat[k]) pat_bcd = 4'(k);
    end
  end

  // Two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      ks    <= '0;
    end else begin
      sync1 <= bus.keys;
      ks    <= sync1;
    end
  end

  // Debounce/accept FSM with registered entry outputs; clear overrides any accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      pat         <= '0;
      cnt         <= '0;
      digits      <= '0;
      count       <= '0;
      digit_valid <= 1'b0;
      digit_bcd   <= '0;
      error       <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      error       <= 1'b0;
      if (bus.clear) begin
        digits <= '0;
        count  <= '0;
        cnt    <= '0;
        state  <= StWaitRel;
      end else begin
        unique case (state)
          StIdle: begin
            if (ks != '0) begin
              pat   <= ks;
              cnt   <= CntW'(1);
              state <= StPressDb;
            end
          end
          StPressDb: begin
            if (ks != pat) begin
              // Bounce: abandon silently.
              state <= StIdle;
            end else if (cnt == CntLast) begin
              cnt   <= '0;
              state <= StWaitRel;
              if (!pat_onehot || full) begin
                error <= 1'b1;
              end else begin
                digits      <= (digits << 4) | DigW'(pat_bcd);
                count       <= count + 4'd1;
                digit_bcd   <= pat_bcd;
                digit_valid <= 1'b1;
              end
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
          StWaitRel: begin
            // Any activity restarts the release window, so a held or changed key never repeats.
            if (ks != '0) begin
              cnt <= '0;
            end else if (cnt == CntLast) begin
              cnt   <= '0;
              state <= StIdle;
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
          default: begin
            cnt   <= '0;
            state <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.digits_out  = digits;
  assign bus.count       = count;
  assign bus.full        = full;
  assign bus.digit_valid = digit_valid;
  assign bus.digit_bcd   = digit_bcd;
  assign bus.error       = error;

endmodule
